// File: rtl/weight_mem_ctrl.sv
// Weight memory controller: loads a full weight set into an external
// single-port memory, then streams it out in address order on request.
module weight_mem_ctrl #(
  parameter int unsigned inWidth     = 121,
  parameter int unsigned weightWidth = 16,
  parameter int unsigned memoryDepth = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic signed [weightWidth-1:0] load_data,
  output logic                          load_ready,
  output logic                          loaded,
  input  logic                          stream_req,
  output logic                          stream_ack,
  output logic                          out_valid,
  output logic signed [weightWidth-1:0] out_data,
  output logic [memoryDepth-1:0]        out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic [memoryDepth-1:0]        mem_address,
  output logic signed [weightWidth-1:0] mem_data_in,
  output logic                          mem_write_enable,
  output logic                          mem_reset,
  input  logic signed [weightWidth-1:0] mem_data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [memoryDepth-1:0] LAST_IDX = memoryDepth'(inWidth - 1);
  localparam logic [memoryDepth-1:0] ONE      = memoryDepth'(1);

  logic [1:0]                    state_q, state_d;
  logic [memoryDepth-1:0]        wptr_q, wptr_d;
  logic [memoryDepth-1:0]        rptr_q, rptr_d;
  logic                          loaded_q, loaded_d;
  logic                          ack_q, ack_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic [memoryDepth-1:0]        out_index_q, out_index_d;
  logic signed [weightWidth-1:0] out_data_q;

  // State and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      loaded_q    <= 1'b0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      loaded_q    <= loaded_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
    end
  end

  // Hold register for out_data between valid cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q <= '0;
    end else if (out_valid_q) begin
      out_data_q <= mem_data_out;
    end
  end

  // Next-state logic; the read pipeline trails the address by one cycle
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    loaded_d    = loaded_q;
    ack_d       = 1'b0;
    out_valid_d = (state_q == S_STREAM);
    out_last_d  = (state_q == S_STREAM) && (rptr_q == LAST_IDX);
    out_index_d = (state_q == S_STREAM) ? rptr_q : out_index_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          state_d  = S_LOAD;
          loaded_d = 1'b0;
          wptr_d   = '0;
        end else if (stream_req && loaded_q) begin
          state_d = S_STREAM;
          rptr_d  = '0;
          ack_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          if (wptr_q == LAST_IDX) begin
            loaded_d = 1'b1;
            wptr_d   = '0;
            state_d  = S_IDLE;
          end else begin
            wptr_d = wptr_q + ONE;
          end
        end
      end
      S_STREAM: begin
        if (rptr_q == LAST_IDX) begin
          rptr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          rptr_d = rptr_q + ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory port and status decode from registered state
  always_comb begin
    mem_address      = '0;
    mem_data_in      = '0;
    mem_write_enable = 1'b0;
    if (state_q == S_LOAD) begin
      mem_address      = wptr_q;
      mem_data_in      = load_data;
      mem_write_enable = load_valid;
    end else if (state_q == S_STREAM) begin
      mem_address = rptr_q;
    end
  end

  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign loaded     = loaded_q;
  assign stream_ack = ack_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_index  = out_index_q;
  assign out_data   = out_valid_q ? mem_data_out : out_data_q;
  assign mem_reset  = ~reset;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Bench for weight_mem_ctrl with a behavioural single-port memory attached.
module tb_weight_mem_ctrl;

  localparam int N = 121;
  localparam int W = 16;
  localparam int D = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         loaded;
  logic         stream_req;
  logic         stream_ack;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [D-1:0] out_index;
  logic         out_last;
  logic         busy;
  logic [D-1:0] mem_address;
  logic [W-1:0] mem_data_in;
  logic         mem_write_enable;
  logic         mem_reset;
  logic [W-1:0] mem_data_out;

  logic [W-1:0] mem_m [0:(1<<D)-1];

  int n_cmp  = 0;
  int n_fail = 0;

  int wq_a[$];
  int wq_d[$];
  int sq_i[$];
  int sq_d[$];

  weight_mem_ctrl #(.inWidth(N), .weightWidth(W), .memoryDepth(D)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .loaded(loaded), .stream_req(stream_req), .stream_ack(stream_ack),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_reset(mem_reset), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory: registered read, read port frozen during writes, async clear
  always @(posedge clk or posedge mem_reset) begin
    if (mem_reset) begin
      for (int i = 0; i < (1<<D); i++) mem_m[i] <= '0;
      mem_data_out <= '0;
    end else if (mem_write_enable) begin
      mem_m[mem_address] <= mem_data_in;
    end else begin
      mem_data_out <= mem_m[mem_address];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || loaded !== 1'b0 || load_ready !== 1'b0 || stream_ack !== 1'b0)
      begin n_fail++; $display("FAIL reset_status: busy=%b loaded=%b ready=%b ack=%b, want all 0", busy, loaded, load_ready, stream_ack); end
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'd0 || out_index !== 7'd0)
      begin n_fail++; $display("FAIL reset_out: valid=%b last=%b data=%0d idx=%0d, want 0", out_valid, out_last, out_data, out_index); end
    n_cmp++;
    if (mem_address !== 7'd0 || mem_data_in !== 16'd0 || mem_write_enable !== 1'b0 || mem_reset !== 1'b1)
      begin n_fail++; $display("FAIL reset_mem: addr=%0d din=%0d we=%b mrst=%b, want 0/0/0/1", mem_address, mem_data_in, mem_write_enable, mem_reset); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_reset !== 1'b0) begin n_fail++; $display("FAIL mem_reset_release: got %b want 0", mem_reset); end
    @(posedge clk); #1;
  endtask

  task automatic do_load(input bit gapped, input bit first_idle);
    int acc, cnt, cyc, ea, ed, bad;
    bit chk_ld;
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < N; i++) begin wq_a.push_back(i); wq_d.push_back(100 + i); end
    acc = 0; cnt = 0; cyc = 0; chk_ld = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'(100);
    forever begin
      @(negedge clk);
      if (first_idle && cyc == 0) begin
        n_cmp++;
        if (load_ready !== 1'b0 || stream_ack !== 1'b0)
          begin n_fail++; $display("FAIL load_first_idle: ready=%b ack=%b want 0/0", load_ready, stream_ack); end
      end
      if (load_ready === 1'b1 && !chk_ld) begin
        chk_ld = 1'b1;
        n_cmp++;
        if (loaded !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_enter: loaded=%b busy=%b want 0/1", loaded, busy); end
      end
      n_cmp++;
      if (mem_write_enable !== (load_valid & load_ready))
        begin n_fail++; $display("FAIL load_we: we=%b valid=%b ready=%b", mem_write_enable, load_valid, load_ready); end
      if (mem_write_enable === 1'b1) begin
        n_cmp++;
        if (wq_a.size() == 0) begin
          n_fail++; $display("FAIL load_extra_write: addr=%0d data=%0d, want none", mem_address, mem_data_in);
        end else begin
          ea = wq_a.pop_front(); ed = wq_d.pop_front();
          if (mem_address !== 7'(ea) || mem_data_in !== 16'(ed))
            begin n_fail++; $display("FAIL load_write: addr=%0d data=%0d want addr=%0d data=%0d", mem_address, mem_data_in, ea, ed); end
        end
      end
      if (load_valid && load_ready === 1'b1) acc++;
      cyc++;
      @(posedge clk); #1;
      if (acc == N) break;
      if (cyc > 1000) begin
        n_cmp++; n_fail++; $display("FAIL load_timeout: accepted %0d want %0d", acc, N);
        break;
      end
      cnt++;
      load_valid = gapped ? ((cnt % 3) != 2) : 1'b1;
      load_data  = 16'(100 + acc);
    end
    load_valid = 1'b0;
    load_data  = '0;
    @(negedge clk);
    n_cmp++;
    if (loaded !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0 || stream_ack !== 1'b0)
      begin n_fail++; $display("FAIL load_done: loaded=%b busy=%b ready=%b ack=%b want 1/0/0/0", loaded, busy, load_ready, stream_ack); end
    n_cmp++;
    if (wq_a.size() != 0) begin n_fail++; $display("FAIL load_missing: %0d writes outstanding, want 0", wq_a.size()); end
    bad = 0;
    for (int i = 0; i < N; i++) if (mem_m[i] !== 16'(100 + i)) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL load_image: %0d wrong words, want 0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input bit keep_req, input int load_at, output int waited);
    int ei, ed;
    waited = 0;
    forever begin
      @(negedge clk);
      if (stream_ack === 1'b1) break;
      waited++;
      @(posedge clk); #1;
      if (waited > 20) begin
        n_cmp++; n_fail++; $display("FAIL stream_ack_timeout: no ack after %0d cycles", waited);
        return;
      end
    end
    n_cmp++;
    if (mem_address !== 7'd0 || mem_write_enable !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL stream_c0: addr=%0d we=%b busy=%b valid=%b want 0/0/1/0", mem_address, mem_write_enable, busy, out_valid); end
    sq_i.delete(); sq_d.delete();
    for (int k = 0; k < N; k++) begin sq_i.push_back(k); sq_d.push_back(100 + k); end
    for (int c = 1; c <= N; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !keep_req) stream_req = 1'b0;
      if (c == load_at) begin load_valid = 1'b1; load_data = 16'(100); end
      @(negedge clk);
      if (c <= N - 1) begin
        n_cmp++;
        if (mem_address !== 7'(c) || mem_write_enable !== 1'b0)
          begin n_fail++; $display("FAIL stream_addr: c=%0d addr=%0d we=%b want addr=%0d we=0", c, mem_address, mem_write_enable, c); end
      end
      n_cmp++;
      if (load_ready !== 1'b0 || busy !== 1'b1 || stream_ack !== 1'b0)
        begin n_fail++; $display("FAIL stream_status: c=%0d ready=%b busy=%b ack=%b want 0/1/0", c, load_ready, busy, stream_ack); end
      n_cmp++;
      if (out_valid !== 1'b1 || sq_i.size() == 0) begin
        n_fail++; $display("FAIL stream_valid: c=%0d valid=%b want 1", c, out_valid);
      end else begin
        ei = sq_i.pop_front(); ed = sq_d.pop_front();
        if (out_index !== 7'(ei) || out_data !== 16'(ed) || out_last !== 1'(ei == N - 1))
          begin n_fail++; $display("FAIL stream_data: idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b", out_index, out_data, out_last, ei, ed, (ei == N - 1)); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || stream_ack !== 1'b0 || load_ready !== 1'b0)
      begin n_fail++; $display("FAIL stream_idle: busy=%b valid=%b last=%b ack=%b ready=%b want all 0", busy, out_valid, out_last, stream_ack, load_ready); end
    n_cmp++;
    if (out_data !== 16'(100 + N - 1) || out_index !== 7'(N - 1))
      begin n_fail++; $display("FAIL stream_hold: data=%0d idx=%0d want %0d/%0d", out_data, out_index, 100 + N - 1, N - 1); end
    n_cmp++;
    if (mem_address !== 7'd0 || mem_write_enable !== 1'b0 || mem_data_in !== 16'd0)
      begin n_fail++; $display("FAIL idle_mem: addr=%0d we=%b din=%0d want 0", mem_address, mem_write_enable, mem_data_in); end
    @(posedge clk); #1;
  endtask

  task automatic test_req_unloaded();
    int w;
    stream_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (stream_ack !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL unloaded_req: ack=%b busy=%b want 0/0", stream_ack, busy); end
      @(posedge clk); #1;
    end
    do_load(1'b0, 1'b1);
    run_stream(1'b0, -1, w);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL ack_after_load: waited %0d want 0", w); end
  endtask

  task automatic test_load_gap();
    stream_req = 1'b0;
    do_load(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int w;
    stream_req = 1'b1;
    run_stream(1'b1, -1, w);
    run_stream(1'b0, 30, w);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL back_to_back_gap: waited %0d want 0", w); end
    do_load(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    int w;
    bit hit;
    stream_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stream_ack === 1'b1) stream_req = 1'b0;
      if (out_valid === 1'b1 && out_index === 7'd60) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL reset_stream_reach: index 60 not seen"); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || mem_reset !== 1'b1 || loaded !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_abort: valid=%b mrst=%b loaded=%b busy=%b want 0/1/0/0", out_valid, mem_reset, loaded, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || mem_write_enable !== 1'b0 || out_data !== 16'd0 || mem_address !== 7'd0)
        begin n_fail++; $display("FAIL reset_hold: valid=%b we=%b data=%0d addr=%0d want 0", out_valid, mem_write_enable, out_data, mem_address); end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    stream_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (stream_ack !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0)
        begin n_fail++; $display("FAIL reset_req_ignored: ack=%b busy=%b loaded=%b want 0", stream_ack, busy, loaded); end
      @(posedge clk); #1;
    end
    do_load(1'b1, 1'b1);
    run_stream(1'b0, -1, w);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL reload_ack: waited %0d want 0", w); end
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    stream_req = 1'b0;
    test_reset();
    test_req_unloaded();
    test_load_gap();
    test_back_to_back();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_mem_ctrl.md
WEIGHT_MEM_CTRL -- requirements
Module: weight_mem_ctrl

Interface
REQ-001 The block SHALL have parameter inWidth, default 121, giving the number of weights (memory words).
REQ-002 The block SHALL have parameter weightWidth, default 16, giving the weight width in bits.
REQ-003 The block SHALL have parameter memoryDepth, default 7, giving the address width; 2^memoryDepth >= inWidth.
REQ-004 The block SHALL have ports:
- clk  input  1  — single clock, rising edge.
- reset  input  1  — asynchronous, active-low.
- load_valid  input  1  — loader offers a weight.
- load_data  input  weightWidth  — weight value, signed.
- load_ready  output  1  — controller accepts load_data this cycle.
- loaded  output  1  — full weight set present in memory.
- stream_req  input  1  — consumer requests a full weight stream; level, held until ack.
- stream_ack  output  1  — one-cycle pulse: request granted.
- out_valid  output  1  — out_data/out_index valid this cycle.
- out_data  output  weightWidth  — streamed weight, signed.
- out_index  output  memoryDepth  — address of out_data.
- out_last  output  1  — marks index inWidth-1.
- busy  output  1  — state is not IDLE.
- mem_address  output  memoryDepth  — to memory address.
- mem_data_in  output  weightWidth  — to memory data_in.
- mem_write_enable  output  1  — to memory write_enable.
- mem_reset  output  1  — to memory reset, active-high.
- mem_data_out  input  weightWidth  — from memory data_out; registered, 1-cycle read latency, updates only when mem_write_enable=0.

Function
REQ-005 The controller SHALL implement states IDLE, LOAD, STREAM, DRAIN; busy=1 in all states except IDLE.
REQ-006 From IDLE, load_valid=1 SHALL transition to LOAD next cycle, clear loaded, and zero the write pointer.
REQ-007 From IDLE with load_valid=0, stream_req=1 and loaded=1, the block SHALL pulse stream_ack for one cycle, present mem_address=0 with mem_write_enable=0 in that cycle, and enter STREAM.
REQ-008 A simultaneous load_valid and stream_req in IDLE SHALL grant the load; stream_req stays pending.
REQ-009 stream_req with loaded=0 SHALL be ignored: no ack and no state change.
REQ-010 In LOAD, load_ready SHALL be 1.
REQ-011 In LOAD, mem_write_enable SHALL equal load_valid, mem_address SHALL equal the write pointer, and mem_data_in SHALL equal load_data.
REQ-012 In LOAD, each cycle with load_valid=1 SHALL write one word and increment the write pointer.
REQ-013 In LOAD, load_valid=0 SHALL pause the load: no write and no pointer change.
REQ-014 The write at pointer inWidth-1 SHALL set loaded=1, reset the pointer to 0, and return to IDLE next cycle.
REQ-015 In STREAM, mem_write_enable SHALL be 0.
REQ-016 In STREAM, mem_address SHALL advance by 1 per cycle, with address 0 presented in the ack cycle, through inWidth-1; the state SHALL then go to DRAIN.
REQ-017 out_valid SHALL be 1 exactly in the inWidth consecutive cycles following each address presentation.
REQ-018 In each out_valid cycle, out_data SHALL equal mem_data_out and out_index SHALL equal the address presented in the previous cycle.
REQ-019 The stream SHALL have no backpressure; the consumer SHALL accept one weight per cycle.
REQ-020 out_last SHALL be 1 only with out_valid when out_index=inWidth-1; that cycle SHALL be DRAIN, and the state SHALL be IDLE on the next cycle.
REQ-021 Cycle-level stream timing, with the ack at cycle c0: index k on cycle c(k+1); last weight on c(inWidth); IDLE on c(inWidth+1).
REQ-022 load_valid during STREAM/DRAIN SHALL see load_ready=0 and SHALL be served only after return to IDLE.
REQ-023 stream_req held through an ack SHALL start a new stream only after return to IDLE; back-to-back streams SHALL be separated by one IDLE cycle.
REQ-024 Outside STREAM/DRAIN, out_valid, out_last and stream_ack SHALL be 0; out_data and out_index hold their last values.
REQ-025 In IDLE, mem_address SHALL be 0, mem_write_enable 0 and mem_data_in 0.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, pointers 0 and loaded=0.
REQ-027 reset=0 SHALL asynchronously force all registered outputs to 0: load_ready, stream_ack, out_valid, out_data, out_index, out_last, busy, mem_address, mem_data_in, mem_write_enable.
REQ-028 mem_reset SHALL equal ~reset combinationally, so memory contents clear together with the controller.
REQ-029 Reset asserted mid-LOAD or mid-STREAM SHALL abort with no further writes or out_valid; after release, loaded=0 and a full reload is required.

Verification
REQ-030 Load 121 words (value = 100+i) back-to-back → 121 writes at addresses 0..120; loaded=1 from the cycle after the last write; busy low after that.
REQ-031 Load with load_valid low every third cycle → writes occur only on valid cycles; the memory image is identical to REQ-030.
REQ-032 After load, hold stream_req → ack at c0; out_data=100+k, out_index=k on c(k+1); out_last only at c121 with data 220; IDLE at c122.
REQ-033 stream_req with loaded=0 → no ack for 10 cycles; then load_valid and stream_req raised together → load granted first, then the stream acked one cycle after the load completes.
REQ-034 Hold stream_req continuously → two full streams separated by exactly one IDLE cycle; load_valid asserted mid-stream sees load_ready=0 until IDLE.
REQ-035 Assert reset at stream index 60 → out_valid=0 immediately, mem_reset=1, loaded=0; after release, stream_req is ignored until a reload completes.
